// File: rtl/antenna_synth.sv
// antenna_synth: three-antenna synthetic sine source, common frequency, programmable phase
// offsets on antennas 2/3, framed output. Define ANTENNA_SYNTH_NOISE_EN to add LFSR dither.
module antenna_synth #(
    parameter int DATA_WIDTH  = 14,
    parameter int PHASE_WIDTH = 32,
    parameter int LUT_ADDR    = 10,
    parameter int FRAME_LOG2  = 11,
    parameter int SAMPLE_DIV  = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [15:0]            n_frames_i,
    input  logic [PHASE_WIDTH-1:0] freq_word_i,
    input  logic [PHASE_WIDTH-1:0] phase_off2_i,
    input  logic [PHASE_WIDTH-1:0] phase_off3_i,
    input  logic [3:0]             amp_shift_i,
    output logic [DATA_WIDTH-1:0]  data1_o,
    output logic [DATA_WIDTH-1:0]  data2_o,
    output logic [DATA_WIDTH-1:0]  data3_o,
    output logic                   valid_o,
    output logic                   frame_start_o,
    output logic                   busy_o,
    output logic [15:0]            frame_count_o,
    output logic                   state_o
);

    localparam int LUT_DEPTH = 1 << LUT_ADDR;
    localparam int DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Latched run configuration.
    logic [15:0]            n_frames_q;
    logic [PHASE_WIDTH-1:0] freq_q, off2_q, off3_q;
    logic [3:0]             amp_q;

    logic [PHASE_WIDTH-1:0] p_q;
    logic [FRAME_LOG2-1:0]  idx_q;
    logic [DIV_W-1:0]       div_q;
    logic                   stop_pending_q;

    logic                          vld1_q, first1_q, last1_q;
    logic signed [DATA_WIDTH-1:0]  s1_q, s2_q, s3_q;
    logic [DATA_WIDTH-1:0]         data1_q, data2_q, data3_q;
    logic                          valid_q, fstart_q;
    logic [15:0]                   fcount_q;

    logic strobe, last_strobe, frames_done, start_acc, busy;
    logic [LUT_ADDR-1:0] addr1, addr2, addr3;
    logic [1:0] nz1, nz2, nz3;

    // Shared full-wave sine table, computed at elaboration.
    function automatic logic signed [DATA_WIDTH-1:0] sine_entry(input int k);
        real x;
        int  r;
        x = (2.0 ** (DATA_WIDTH - 1) - 1.0) *
            $sin(6.283185307179586 * k / (2.0 ** LUT_ADDR));
        r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        return DATA_WIDTH'(r);
    endfunction

    logic signed [DATA_WIDTH-1:0] lut [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        assign lut[k] = sine_entry(k);
    end

    // Attenuate, add dither, shift to offset binary and clamp to the code range.
    function automatic logic [DATA_WIDTH-1:0] shape(input logic signed [DATA_WIDTH-1:0] s,
                                                   input logic [3:0] sh,
                                                   input logic [1:0] nz);
        logic signed [DATA_WIDTH-1:0] a;
        logic signed [DATA_WIDTH+1:0] sum;
        a   = s >>> sh;
        sum = (DATA_WIDTH+2)'(a) + (DATA_WIDTH+2)'($signed(nz))
            + $signed((DATA_WIDTH+2)'(MID));
        if (sum[DATA_WIDTH+1]) begin
            return '0;
        end else if (sum[DATA_WIDTH]) begin
            return '1;
        end
        return sum[DATA_WIDTH-1:0];
    endfunction

    // valid_o is a one-cycle qualifier with no backpressure: every sample must be taken
    // in the cycle it is presented; frame_start_o is meaningful only while valid_o is high.
    assign busy = (state_q == S_RUN) || vld1_q || valid_q;

    assign addr1 = p_q[PHASE_WIDTH-1 -: LUT_ADDR];
    assign addr2 = LUT_ADDR'((p_q + off2_q) >> (PHASE_WIDTH - LUT_ADDR));
    assign addr3 = LUT_ADDR'((p_q + off3_q) >> (PHASE_WIDTH - LUT_ADDR));

    always_comb begin
        state_d     = state_q;
        start_acc   = 1'b0;
        strobe      = (state_q == S_RUN) && (div_q == '0);
        last_strobe = strobe && (idx_q == '1);
        frames_done = (n_frames_q != 16'd0) &&
                      ((17'(fcount_q) + 17'd1) == 17'(n_frames_q));
        case (state_q)
            S_IDLE: begin
                if (start_i && !busy) begin
                    start_acc = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (last_strobe && (stop_pending_q || stop_i || frames_done)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= S_IDLE;
            n_frames_q     <= '0;
            freq_q         <= '0;
            off2_q         <= '0;
            off3_q         <= '0;
            amp_q          <= '0;
            p_q            <= '0;
            idx_q          <= '0;
            div_q          <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                n_frames_q     <= n_frames_i;
                freq_q         <= freq_word_i;
                off2_q         <= phase_off2_i;
                off3_q         <= phase_off3_i;
                amp_q          <= amp_shift_i;
                p_q            <= '0;
                idx_q          <= '0;
                div_q          <= '0;
                stop_pending_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                if (stop_i) begin
                    stop_pending_q <= 1'b1;
                end
                if (state_d == S_IDLE || div_q == DIV_W'(SAMPLE_DIV - 1)) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
                if (strobe) begin
                    p_q   <= p_q + freq_q;
                    idx_q <= idx_q + FRAME_LOG2'(1);
                end
            end
        end
    end

`ifdef ANTENNA_SYNTH_NOISE_EN
    localparam logic [15:0] SEED1 = 16'hACE1;
    localparam logic [15:0] SEED2 = 16'hBEEF;
    localparam logic [15:0] SEED3 = 16'h1234;

    logic [15:0] lfsr1_q, lfsr2_q, lfsr3_q;
    logic [1:0]  nz1_q, nz2_q, nz3_q;

    // Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lfsr1_q <= SEED1;
            lfsr2_q <= SEED2;
            lfsr3_q <= SEED3;
            nz1_q   <= '0;
            nz2_q   <= '0;
            nz3_q   <= '0;
        end else if (start_acc) begin
            lfsr1_q <= SEED1;
            lfsr2_q <= SEED2;
            lfsr3_q <= SEED3;
        end else if (strobe) begin
            nz1_q   <= lfsr1_q[1:0];
            nz2_q   <= lfsr2_q[1:0];
            nz3_q   <= lfsr3_q[1:0];
            lfsr1_q <= lfsr_step(lfsr1_q);
            lfsr2_q <= lfsr_step(lfsr2_q);
            lfsr3_q <= lfsr_step(lfsr3_q);
        end
    end

    assign nz1 = nz1_q;
    assign nz2 = nz2_q;
    assign nz3 = nz3_q;
`else
    assign nz1 = 2'b00;
    assign nz2 = 2'b00;
    assign nz3 = 2'b00;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld1_q   <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            data1_q  <= MID;
            data2_q  <= MID;
            data3_q  <= MID;
            valid_q  <= 1'b0;
            fstart_q <= 1'b0;
            fcount_q <= '0;
        end else begin
            vld1_q <= strobe;
            if (strobe) begin
                s1_q     <= lut[addr1];
                s2_q     <= lut[addr2];
                s3_q     <= lut[addr3];
                first1_q <= (idx_q == '0);
                last1_q  <= (idx_q == '1);
            end
            valid_q  <= vld1_q;
            fstart_q <= vld1_q && first1_q;
            if (vld1_q) begin
                data1_q <= shape(s1_q, amp_q, nz1);
                data2_q <= shape(s2_q, amp_q, nz2);
                data3_q <= shape(s3_q, amp_q, nz3);
            end
            // The count becomes visible together with the last sample of the frame.
            if (start_acc) begin
                fcount_q <= '0;
            end else if (vld1_q && last1_q && fcount_q != 16'hFFFF) begin
                fcount_q <= fcount_q + 16'd1;
            end
        end
    end

    assign data1_o       = data1_q;
    assign data2_o       = data2_q;
    assign data3_o       = data3_q;
    assign valid_o       = valid_q;
    assign frame_start_o = fstart_q;
    assign busy_o        = busy;
    assign frame_count_o = fcount_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_antenna_synth.sv
// Bench for antenna_synth: a sine-table reference model predicts each emitted sample
// from its index, the run parameters and the phase rules.
module tb_antenna_synth;

    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start4, stop;
    logic [15:0] n_frames;
    logic [31:0] freq, off2, off3;
    logic [3:0]  amp;

    logic [13:0] d1, d2, d3, e1, e2, e3;
    logic        valid, fs, busy, st;
    logic [15:0] fc;
    logic [13:0] d1_4, d2_4, d3_4;
    logic        valid4, fs4, busy4, st4;
    logic [15:0] fc4;

    int n_cmp = 0;
    int n_bad = 0;
    int sin_tab [1024];

    always #5 clk = ~clk;

    antenna_synth dut (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .stop_i(stop),
        .n_frames_i(n_frames), .freq_word_i(freq), .phase_off2_i(off2), .phase_off3_i(off3),
        .amp_shift_i(amp), .data1_o(d1), .data2_o(d2), .data3_o(d3), .valid_o(valid),
        .frame_start_o(fs), .busy_o(busy), .frame_count_o(fc), .state_o(st)
    );

    antenna_synth #(.SAMPLE_DIV(4)) dut4 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start4), .stop_i(stop),
        .n_frames_i(n_frames), .freq_word_i(freq), .phase_off2_i(off2), .phase_off3_i(off3),
        .amp_shift_i(amp), .data1_o(d1_4), .data2_o(d2_4), .data3_o(d3_4), .valid_o(valid4),
        .frame_start_o(fs4), .busy_o(busy4), .frame_count_o(fc4), .state_o(st4)
    );

    // Sample n of a run: phase n*freq + offset, top 10 bits index the sine, then attenuate.
    function automatic logic [13:0] model(input int n, input logic [31:0] fw,
                                          input logic [31:0] off, input logic [3:0] sh);
        logic [31:0] ph;
        int          s;
        ph = 32'(n) * fw + off;
        s  = sin_tab[ph[31:22]];
        s  = s >>> sh;
        return 14'(8192 + s);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; stop = 1'b0;
        n_frames = '0; freq = '0; off2 = '0; off3 = '0; amp = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (d1 !== 14'h2000) begin n_bad++; $display("FAIL reset_data1: got %h want 2000", d1); end
        n_cmp++; if (d2 !== 14'h2000) begin n_bad++; $display("FAIL reset_data2: got %h want 2000", d2); end
        n_cmp++; if (d3 !== 14'h2000) begin n_bad++; $display("FAIL reset_data3: got %h want 2000", d3); end
        n_cmp++; if ({valid, fs, busy, st} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {valid, fs, busy, st}); end
        n_cmp++; if (fc !== 16'd0) begin n_bad++; $display("FAIL reset_fcount: got %0d want 0", fc); end
        n_cmp++; if ({valid4, busy4, st4} !== 3'b0 || d1_4 !== 14'h2000) begin n_bad++; $display("FAIL reset_dut4: got %b/%h want 000/2000", {valid4, busy4, st4}, d1_4); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_sample();
        int cyc;
        freq = '0; off2 = '0; off3 = '0; amp = '0; n_frames = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin n_bad++; $display("FAIL first_run_cycle: got busy=%b valid=%b want 1/0", busy, valid); end
        @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL first_latency1: got valid=%b want 0", valid); end
        @(negedge clk);
        n_cmp++; if (valid !== 1'b1 || fs !== 1'b1) begin n_bad++; $display("FAIL first_latency2: got valid=%b fs=%b want 1/1", valid, fs); end
        n_cmp++; if ({d1, d2, d3} !== {3{14'h2000}}) begin n_bad++; $display("FAIL first_data: got %h %h %h want 2000 x3", d1, d2, d3); end
        cyc = 0;
        while (busy && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL first_timeout: busy=%b after %0d cycles want 0", busy, cyc); end
    endtask

    // Starts a run and checks every emitted sample against the model until busy drops.
    task automatic run_check(input string name, input logic [15:0] nfr, input logic [31:0] fw,
                             input logic [31:0] o2, input logic [31:0] o3, input logic [3:0] sh,
                             input int stop_at, input int exp_count, input int exp_fc,
                             input bit poke);
        int seen, cyc;
        bit prev_valid;
        n_frames = nfr; freq = fw; off2 = o2; off3 = o3; amp = sh;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy_rise: got %b want 1", name, busy); end
        seen = 0; cyc = 0; prev_valid = 1'b0;
        while (busy && cyc < BUDGET) begin
            stop = 1'b0; start = 1'b0;
            if (valid) begin
                e1 = model(seen, fw, 32'd0, sh);
                e2 = model(seen, fw, o2, sh);
                e3 = model(seen, fw, o3, sh);
                n_cmp++; if (d1 !== e1) begin n_bad++; $display("FAIL %s_data1[%0d]: got %h want %h", name, seen, d1, e1); end
                n_cmp++; if (d2 !== e2) begin n_bad++; $display("FAIL %s_data2[%0d]: got %h want %h", name, seen, d2, e2); end
                n_cmp++; if (d3 !== e3) begin n_bad++; $display("FAIL %s_data3[%0d]: got %h want %h", name, seen, d3, e3); end
                n_cmp++; if (fs !== ((seen % 2048) == 0)) begin n_bad++; $display("FAIL %s_frame_start[%0d]: got %b", name, seen, fs); end
                if ((seen % 2048) != 2047) begin
                    n_cmp++; if (fc !== 16'(seen / 2048)) begin n_bad++; $display("FAIL %s_fcount[%0d]: got %0d want %0d", name, seen, fc, seen / 2048); end
                end
                if (seen == stop_at) stop = 1'b1;
                if (poke && (seen == 1000 || seen == exp_count - 1)) start = 1'b1;
                seen++;
            end
            prev_valid = valid;
            @(negedge clk);
            cyc++;
        end
        stop = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_timeout: busy=%b after %0d cycles want 0", name, busy, cyc); end
        n_cmp++; if (seen != exp_count) begin n_bad++; $display("FAIL %s_count: got %0d samples want %0d", name, seen, exp_count); end
        n_cmp++; if (prev_valid !== 1'b1 || valid !== 1'b0) begin n_bad++; $display("FAIL %s_busy_fall: got last_valid=%b valid=%b want 1/0", name, prev_valid, valid); end
        n_cmp++; if (fc !== 16'(exp_fc)) begin n_bad++; $display("FAIL %s_fcount_end: got %0d want %0d", name, fc, exp_fc); end
    endtask

    task automatic test_offsets();
        run_check("offsets", 16'd1, 32'd0, 32'h4000_0000, 32'hC000_0000, 4'd0, -1, 2048, 1, 1'b0);
        n_cmp++; if (d1 !== 14'h2000 || d2 !== 14'h3FFF || d3 !== 14'h0001) begin
            n_bad++; $display("FAIL offsets_hold: got %h %h %h want 2000 3fff 0001", d1, d2, d3);
        end
    endtask

    task automatic test_n_frames();
        run_check("nframes2", 16'd2, $urandom, $urandom, $urandom, 4'($urandom_range(0, 3)), -1, 4096, 2, 1'b0);
    endtask

    task automatic test_stop();
        run_check("stop_mid", 16'd0, $urandom, $urandom, $urandom, 4'd1, 100, 2048, 1, 1'b0);
        run_check("stop_last", 16'd0, $urandom, $urandom, $urandom, 4'd0, 2045, 2048, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            run_check("random", 16'd1, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
                      -1, 2048, 1, (i == 0));
        end
    endtask

    task automatic test_sample_div();
        int cyc, k;
        freq = 32'h0040_0000; off2 = '0; off3 = '0; amp = 4'd2; n_frames = 16'd0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 0; k = 0;
        while (k < 40 && cyc < BUDGET) begin
            if (valid4) begin
                e1 = model(k, freq, 32'd0, 4'd2);
                n_cmp++; if (cyc != 2 + 4 * k) begin n_bad++; $display("FAIL div4_timing[%0d]: got cycle %0d want %0d", k, cyc, 2 + 4 * k); end
                n_cmp++; if (d1_4 !== e1 || d3_4 !== e1) begin n_bad++; $display("FAIL div4_data[%0d]: got %h/%h want %h", k, d1_4, d3_4, e1); end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (k != 40) begin n_bad++; $display("FAIL div4_timeout: got %0d samples want 40", k); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy4 !== 1'b0 || d2_4 !== 14'h2000 || fs4 !== 1'b0 || fc4 !== 16'd0) begin
            n_bad++; $display("FAIL div4_reset: got busy=%b data=%h fs=%b fc=%0d want 0/2000/0/0", busy4, d2_4, fs4, fc4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int seen, cyc;
        n_frames = 16'd0; freq = $urandom; off2 = $urandom; off3 = $urandom; amp = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0; cyc = 0;
        while (seen <= 500 && cyc < BUDGET) begin
            if (valid) seen++;
            if (seen <= 500) begin
                @(negedge clk);
                cyc++;
            end
        end
        n_cmp++; if (seen != 501) begin n_bad++; $display("FAIL midrun_timeout: got %0d samples want 501", seen); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({d1, d2, d3} !== {3{14'h2000}}) begin n_bad++; $display("FAIL midrun_data: got %h %h %h want 2000 x3", d1, d2, d3); end
        n_cmp++; if ({valid, fs, busy, st} !== 4'b0 || fc !== 16'd0) begin n_bad++; $display("FAIL midrun_flags: got %b fc=%0d want 0000/0", {valid, fs, busy, st}, fc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_check("restart", 16'd1, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), -1, 2048, 1, 1'b0);
    endtask

    initial begin
        real x;
        for (int k = 0; k < 1024; k++) begin
            x = 8191.0 * $sin(2.0 * 3.141592653589793 * k / 1024.0);
            sin_tab[k] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        end
        test_reset();
        test_first_sample();
        test_offsets();
        test_n_frames();
        test_stop();
        test_back_to_back();
        test_sample_div();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/antenna_synth.md
Name: antenna_synth

Overview:
- Synthetic three-antenna sample source that drives the same 14-bit per-antenna sample interface the phase-extraction path consumes.
- Generates one common-frequency sine, with a programmable phase offset on antennas #2 and #3, so phase extraction can be checked against known phase differences.
- Output is framed in blocks of 2^FRAME_LOG2 samples to line up with the FFT length.
- Sits in place of the ADC front end in loopback and bring-up builds.

Parameters:
DATA_WIDTH, 14, bits per antenna sample (offset binary)
PHASE_WIDTH, 32, phase accumulator width
LUT_ADDR, 10, log2 of sine table depth
FRAME_LOG2, 11, log2 of samples per frame (2048)
SAMPLE_DIV, 1, clocks per sample strobe (>=1)

Ports:
clk  in  1  main clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: begin generation
stop  in  1  single-cycle pulse: finish current frame, then halt
n_frames  in  16  frames to emit per run; 0 = continuous
freq_word  in  PHASE_WIDTH  phase increment per sample
phase_off2  in  PHASE_WIDTH  phase offset of antenna #2 relative to #1
phase_off3  in  PHASE_WIDTH  phase offset of antenna #3 relative to #1
amp_shift  in  4  amplitude attenuation as a right shift
data1  out  DATA_WIDTH  antenna #1 sample
data2  out  DATA_WIDTH  antenna #2 sample
data3  out  DATA_WIDTH  antenna #3 sample
valid  out  1  data1..3 carry a new sample this cycle
frame_start  out  1  with valid: sample index 0 of a frame
busy  out  1  run in progress
frame_count  out  16  completed frames in the current run

Behaviour:
- Reset (reset low, asynchronous):
  - data1..3 = 2^(DATA_WIDTH-1) (0x2000, midscale).
  - valid, frame_start, busy = 0; frame_count = 0.
  - FSM = IDLE; accumulator, sample index, divider and stop_pending cleared.
  - Reset mid-run aborts immediately with no partial-frame completion.
- FSM states IDLE and RUN.
  - IDLE, start=1: latch n_frames, freq_word, phase_off2/3 and amp_shift. Clear accumulator p, sample index, frame_count and stop_pending. Go to RUN; busy=1 from the next cycle.
  - stop in IDLE is ignored. start in RUN is ignored.
  - RUN, stop=1: set stop_pending.
  - At the strobe of the last sample of a frame (index 2^FRAME_LOG2-1), enter IDLE if stop_pending, or if n_frames!=0 and frame_count+1==n_frames.
  - stop arriving in the same cycle as that last strobe counts for the current frame.
- Sample strobe:
  - Divider counter 0..SAMPLE_DIV-1 runs only in RUN; strobe when it equals 0. The first strobe falls on the first RUN cycle.
  - SAMPLE_DIV=1 gives a strobe every RUN cycle.
- Pipeline, per strobe at cycle t:
  - Stage 0 (t): LUT addresses a_k = (p + off_k)[PHASE_WIDTH-1 -: LUT_ADDR], with off_1=0. Then p <= p + freq_word, modulo 2^PHASE_WIDTH (wraps silently).
  - Stage 1 (t+1): registered LUT reads s_k, signed DATA_WIDTH.
  - Stage 2 (t+2): data_k = 2^(DATA_WIDTH-1) + (s_k >>> amp_shift), offset binary, no overflow possible. valid=1 for exactly one cycle.
  - Fixed latency 2 clocks from strobe to valid.
- LUT:
  - 2^LUT_ADDR full-wave entries, filled at elaboration: s[k] = round((2^(DATA_WIDTH-1)-1)·sin(2πk/2^LUT_ADDR)).
  - Single table shared by all three channels via three read ports.
- Framing:
  - Sample index increments per strobe and wraps at 2^FRAME_LOG2.
  - frame_start=1 together with valid when the emitted sample had index 0.
  - frame_count increments at the output (valid) cycle of index 2^FRAME_LOG2-1. It saturates at 0xFFFF and holds after the run ends until the next start.
- busy:
  - Stays high until the valid cycle of the final sample inclusive, then drops in the next cycle.
  - start is ignored while busy is high, including the 2 pipeline drain cycles after the FSM has returned to IDLE.
- Idle outputs: data1..3 hold the last sample; valid=0.

Optional Feature:
ANTENNA_SYNTH_NOISE_EN:
- Defined:
  - Three independent 16-bit Galois LFSRs (taps x^16+x^14+x^13+x^11+1), seeds 0xACE1, 0xBEEF and 0x1234.
  - Each LFSR advances once per strobe and is reset to its seed at start.
  - The signed value of the LFSR's 2 LSBs (-2..+1) is added in stage 2 before the midscale offset, saturating to 0..2^DATA_WIDTH-1.
- Undefined: no LFSR logic; outputs are exact LUT values.

Test Plan:
1. Reset release, freq_word=0, offsets 0, amp_shift=0, start → valid first asserts 2 cycles after the first RUN cycle; data1=data2=data3=0x2000; frame_start=1 on that sample.
2. freq_word=0, phase_off2=0x40000000, phase_off3=0xC0000000 → data1=0x2000, data2=0x3FFF, data3=0x0001 on every valid.
3. n_frames=2, SAMPLE_DIV=1 → exactly 4096 valid pulses; frame_start on samples 0 and 2048; frame_count=2; busy falls the cycle after the last valid.
4. Continuous run, stop pulsed at sample 100 and again in the last-sample strobe cycle of a later run → emission ends after sample 2047 of the current frame in both cases; frame_count=1.
5. SAMPLE_DIV=4, freq_word=0x00400000 (LUT step 1), amp_shift=2 → valid every 4 clocks; data1 follows 0x2000+(s[k]>>>2) for k=0,1,2…
6. Reset asserted mid-frame at sample 500 → outputs return to 0x2000 and all flags to 0 immediately; a new start restarts at phase 0 with frame_count=0.
